pt_ring_node_arb: RTL and testbench

Ring-node output stage that sits directly downstream of two two-entry register FIFOs: the through FIFO, holding flits arriving from the previous ring hop, and the local FIFO, holding flits injected by the attached agent. It pops flit heads from both FIFOs, ejects through flits addressed to this node, and arbitrates the rest onto the outgoing ring link. The arbitration gives through traffic priority and bounds local starvation. Both outputs are registered, with valid/ready handshakes.

---
 rtl/pt_ring_pkg.sv | 14 +
 rtl/pt_ring_node_arb_if.sv | 23 ++
 rtl/pt_ring_out_reg.sv | 22 ++
 rtl/pt_ring_node_arb.sv | 40 ++++
 tb/tb_pt_ring_node_arb.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/pt_ring_pkg.sv
// pt_ring_pkg: shared flit type, destination decode and starve-counter sizing for the ring node
package pt_ring_pkg;
    localparam int FLIT_W = 8;
    localparam int DEST_W = 2;
    localparam int BURST_DEF = 4;
    typedef logic [FLIT_W-1:0] flit_t;
    function automatic int cnt_w(int max_burst);
        return $clog2(max_burst + 1);
    endfunction
    localparam int STARVE_W = cnt_w(BURST_DEF);
    function automatic logic [DEST_W-1:0] dest_of(flit_t f);
        return f[FLIT_W-1 -: DEST_W];
    endfunction
endpackage

// File: rtl/pt_ring_node_arb_if.sv
// pt_ring_node_arb_if: FIFO-head inputs, pop strobes and ring/eject valid-ready outputs of a ring node
interface pt_ring_node_arb_if #(parameter int WIDTH = 8);
    logic             iThrEmpty;
    logic [WIDTH-1:0] iThrDat;
    logic             oThrRdEn;
    logic             iLocEmpty;
    logic [WIDTH-1:0] iLocDat;
    logic             oLocRdEn;
    logic             oRingVld;
    logic [WIDTH-1:0] oRingDat;
    logic             iRingRdy;
    logic             oEjVld;
    logic [WIDTH-1:0] oEjDat;
    logic             iEjRdy;
    modport slave (
        input  iThrEmpty, iThrDat, iLocEmpty, iLocDat, iRingRdy, iEjRdy,
        output oThrRdEn, oLocRdEn, oRingVld, oRingDat, oEjVld, oEjDat
    );
    modport master (
        output iThrEmpty, iThrDat, iLocEmpty, iLocDat, iRingRdy, iEjRdy,
        input  oThrRdEn, oLocRdEn, oRingVld, oRingDat, oEjVld, oEjDat
    );
endinterface

// File: rtl/pt_ring_out_reg.sv
// pt_ring_out_reg: single-entry valid/ready output register, reloads whenever empty or being drained
module pt_ring_out_reg #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         rdy,
    output logic         vld,
    output logic [W-1:0] dat,
    output logic         load
);
    assign load = !vld || rdy;
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= push;
            if (push) dat <= din;
        end
    end
endmodule

// File: rtl/pt_ring_node_arb.sv
// pt_ring_node_arb: ejects self-addressed through flits, arbitrates the rest with local traffic onto the ring
// Through traffic wins the ring unless local has waited MAX_BURST consecutive through grants.
module pt_ring_node_arb import pt_ring_pkg::*; #(
    parameter int WIDTH     = FLIT_W,
    parameter int ID_W      = DEST_W,
    parameter int NODE_ID   = 0,
    parameter int MAX_BURST = BURST_DEF
) (
    input logic clk,
    input logic rst,
    pt_ring_node_arb_if.slave bus
);
    localparam int SC_W = cnt_w(MAX_BURST);
    logic [SC_W-1:0] starve_cnt;
    logic ring_load, ej_load, thr_self, thr_ring, loc_req, at_max;
    logic grant_thr, grant_loc, ej_pop;
    assign thr_self  = !bus.iThrEmpty && (bus.iThrDat[WIDTH-1 -: ID_W] == ID_W'(NODE_ID));
    assign thr_ring  = !bus.iThrEmpty && !thr_self;
    assign loc_req   = !bus.iLocEmpty;
    assign at_max    = starve_cnt == SC_W'(MAX_BURST);
    assign grant_loc = ring_load && loc_req && (!thr_ring || at_max);
    assign grant_thr = ring_load && thr_ring && !(loc_req && at_max);
    assign ej_pop    = thr_self && ej_load;
    // Pops are combinational so the FIFOs see them in the same cycle the head is consumed.
    assign bus.oThrRdEn = !rst && (ej_pop || grant_thr);
    assign bus.oLocRdEn = !rst && grant_loc;
    always_ff @(posedge clk) begin
        if (rst) starve_cnt <= '0;
        else if (ring_load) starve_cnt <= (!loc_req || grant_loc) ? '0 : at_max ? starve_cnt : starve_cnt + 1'b1;
    end
    pt_ring_out_reg #(.W(WIDTH)) u_ring (
        .clk(clk), .rst(rst), .push(grant_thr || grant_loc),
        .din(grant_loc ? bus.iLocDat : bus.iThrDat), .rdy(bus.iRingRdy),
        .vld(bus.oRingVld), .dat(bus.oRingDat), .load(ring_load)
    );
    pt_ring_out_reg #(.W(WIDTH)) u_ej (
        .clk(clk), .rst(rst), .push(ej_pop), .din(bus.iThrDat), .rdy(bus.iEjRdy),
        .vld(bus.oEjVld), .dat(bus.oEjDat), .load(ej_load)
    );
endmodule

// File: tb/tb_pt_ring_node_arb.sv
// tb_pt_ring_node_arb: directed scenarios with queue-modelled FIFOs and hand-computed expectations
module tb_pt_ring_node_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ring_rdy = 1'b1;
    logic ej_rdy = 1'b1;
    logic thr_rd_s, loc_rd_s;
    logic [7:0] thr_q[$], loc_q[$], ring_got[$], ej_got[$];
    int n_chk = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    pt_ring_node_arb_if #(.WIDTH(8)) bus ();
    pt_ring_node_arb #(.WIDTH(8), .ID_W(2), .NODE_ID(1), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic drive();
        bus.iThrEmpty = thr_q.size() == 0;
        bus.iThrDat   = thr_q.size() ? thr_q[0] : 8'h00;
        bus.iLocEmpty = loc_q.size() == 0;
        bus.iLocDat   = loc_q.size() ? loc_q[0] : 8'h00;
        bus.iRingRdy  = ring_rdy;
        bus.iEjRdy    = ej_rdy;
    endtask
    task automatic cyc();
        logic rv, ev;
        logic [7:0] rd, ed;
        drive();
        #1;
        thr_rd_s = bus.oThrRdEn;
        loc_rd_s = bus.oLocRdEn;
        rv = bus.oRingVld && ring_rdy && !rst;
        ev = bus.oEjVld && ej_rdy && !rst;
        rd = bus.oRingDat;
        ed = bus.oEjDat;
        @(posedge clk);
        #1;
        if (rv) ring_got.push_back(rd);
        if (ev) ej_got.push_back(ed);
        if (thr_rd_s) void'(thr_q.pop_front());
        if (loc_rd_s) void'(loc_q.pop_front());
        drive();
    endtask
    initial begin
        logic [7:0] exp_seq[7];
        exp_seq = '{8'h81, 8'h82, 8'h83, 8'h84, 8'hC7, 8'h86, 8'h87};
        // reset with both FIFOs holding flits
        thr_q = '{8'h85};
        loc_q = '{8'hC3};
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_thr_rd", thr_rd_s, 0);
            chk("rst_loc_rd", loc_rd_s, 0);
            chk("rst_ring_vld", bus.oRingVld, 0);
            chk("rst_ej_vld", bus.oEjVld, 0);
        end
        chk("rst_ring_dat", bus.oRingDat, 0);
        rst = 1'b0;
        cyc();
        chk("post_rst_thr_rd", thr_rd_s, 1);
        chk("post_rst_ring", bus.oRingDat, 8'h85);
        cyc();
        chk("post_rst_loc", bus.oRingDat, 8'hC3);
        cyc();
        chk("post_rst_drain", bus.oRingVld, 0);
        ring_got.delete();
        // self-addressed through flit is ejected
        thr_q = '{8'h45};
        cyc();
        chk("ej_thr_rd", thr_rd_s, 1);
        chk("ej_vld", bus.oEjVld, 1);
        chk("ej_dat", bus.oEjDat, 8'h45);
        chk("ej_ring_vld", bus.oRingVld, 0);
        cyc();
        chk("ej_drain", bus.oEjVld, 0);
        // ring backpressure holds both FIFOs
        ring_rdy = 1'b0;
        loc_q = '{8'h11};
        cyc();
        chk("bp_fill", bus.oRingDat, 8'h11);
        thr_q = '{8'h85};
        loc_q = '{8'hC3};
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("bp_thr_rd", thr_rd_s, 0);
            chk("bp_loc_rd", loc_rd_s, 0);
            chk("bp_hold", bus.oRingDat, 8'h11);
        end
        ring_rdy = 1'b1;
        cyc();
        chk("bp_thr_first", bus.oRingDat, 8'h85);
        cyc();
        chk("bp_loc_next", bus.oRingDat, 8'hC3);
        cyc();
        chk("bp_drain", bus.oRingVld, 0);
        chk("bp_count", ring_got.size(), 3);
        if (ring_got.size() == 3) begin
            chk("bp_got0", ring_got[0], 8'h11);
            chk("bp_got1", ring_got[1], 8'h85);
            chk("bp_got2", ring_got[2], 8'hC3);
        end
        // starvation bound
        loc_q = '{8'hC7};
        thr_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h86, 8'h87};
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("starve_seq", bus.oRingDat, exp_seq[i]);
            if (i == 3) chk("starve_cnt_max", dut.starve_cnt, 4);
            if (i == 4) chk("starve_cnt_clr", dut.starve_cnt, 0);
        end
        cyc();
        chk("starve_drain", bus.oRingVld, 0);
        // eject and local grant together
        thr_q = '{8'h41};
        loc_q = '{8'h82};
        cyc();
        chk("dual_thr_rd", thr_rd_s, 1);
        chk("dual_loc_rd", loc_rd_s, 1);
        chk("dual_ej", bus.oEjDat, 8'h41);
        chk("dual_ring", bus.oRingDat, 8'h82);
        cyc();
        // eject backpressure stalls through only
        ej_rdy = 1'b0;
        thr_q = '{8'h40, 8'h42};
        cyc();
        chk("ejbp_fill", bus.oEjDat, 8'h40);
        loc_q = '{8'h83};
        cyc();
        chk("ejbp_thr_rd", thr_rd_s, 0);
        chk("ejbp_loc_rd", loc_rd_s, 1);
        chk("ejbp_ring", bus.oRingDat, 8'h83);
        chk("ejbp_ej_hold", bus.oEjDat, 8'h40);
        ej_rdy = 1'b1;
        cyc();
        chk("ejbp_release", bus.oEjDat, 8'h42);
        cyc();
        chk("ejbp_drain", bus.oEjVld, 0);
        chk("thr_empty", thr_q.size(), 0);
        chk("loc_empty", loc_q.size(), 0);
        chk("ej_count", ej_got.size(), 4);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
